// File: rtl/surfturf_fw_framer_pkg.sv
// rtl/surfturf_fw_framer_pkg.sv - shared frame layout, FSM states and frame builder for the firmware framer
// Contents: FRAME_W and frame bit positions, fw_state_e, build_frame().
// Optional feature macro: FWFRAMER_PARITY_EN (frame bit 11 = even parity over bits [10:0]).
package surfturf_fw_framer_pkg;

  localparam int FRAME_W       = 12;
  localparam int FRM_DATA_LSB  = 0;
  localparam int FRM_DATA_W    = 8;
  localparam int FRM_VALID_BIT = 8;
  localparam int FRM_MARK_LSB  = 9;
  localparam int FRM_MARK_W    = 2;
  localparam int FRM_PAR_BIT   = 11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_MARKED = 2'd2
  } fw_state_e;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic                  valid,
    input logic [FRM_MARK_W-1:0] mark,
    input logic [FRM_DATA_W-1:0] data
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRM_DATA_LSB +: FRM_DATA_W] = data;
    f[FRM_VALID_BIT]              = valid;
    f[FRM_MARK_LSB +: FRM_MARK_W] = mark;
`ifdef FWFRAMER_PARITY_EN
    f[FRM_PAR_BIT] = ^f[FRM_PAR_BIT-1:0];
`endif
    return f;
  endfunction

endpackage

// File: rtl/surfturf_fw_bytefifo.sv
// rtl/surfturf_fw_bytefifo.sv - DEPTH-entry byte FIFO with combinational head
// Ports: clk, rst_n (async active-low), push/push_data, pop, full, empty, head.
// A push while full is taken only when a pop happens on the same cycle,
// so occupancy stays unchanged in that case.
module surfturf_fw_bytefifo #(
  parameter     SYS_CLK_TYPE = "NONE",
  parameter int DEPTH        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  (* clock_domain = SYS_CLK_TYPE *) logic [CNT_W-1:0] count;

  logic do_push;
  logic do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/surfturf_fw_framer.sv
// rtl/surfturf_fw_framer.sv - packs firmware-update bytes and mark requests into 12-bit command frames
// Ports: sysclk_i, sysrst_n_i (async active-low), fw_tdata/fw_tvalid/fw_tready byte stream,
//        fw_mark_i/fw_marked_o mark handshake, frame_stb_i strobe, frame_o payload, bytes_sent_o.
// Optional feature macro: FWFRAMER_PARITY_EN (frame_o[11] = even parity over frame_o[10:0]).
module surfturf_fw_framer
  import surfturf_fw_framer_pkg::*;
#(
  parameter     SYS_CLK_TYPE = "NONE",
  parameter int DEPTH        = 2
) (
  input  logic               sysclk_i,
  input  logic               sysrst_n_i,
  input  logic [7:0]         fw_tdata,
  input  logic               fw_tvalid,
  output logic               fw_tready,
  input  logic [1:0]         fw_mark_i,
  output logic               fw_marked_o,
  input  logic               frame_stb_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic [15:0]        bytes_sent_o
);

  (* clock_domain = SYS_CLK_TYPE *) fw_state_e state;
  fw_state_e next_state;

  logic               ready_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic [7:0]         fifo_head;
  logic               push;
  logic               pop;
  logic [FRAME_W-1:0] frame_d;
  logic               marked_d;
  logic               data_issue;
  logic               mark_issue;

  // ready_en keeps tready low for the first cycle after reset release.
  assign fw_tready = ready_en && !fifo_full && (state == ST_RUN);
  assign push      = fw_tvalid && fw_tready;

  surfturf_fw_bytefifo #(
    .SYS_CLK_TYPE (SYS_CLK_TYPE),
    .DEPTH        (DEPTH)
  ) u_fifo (
    .clk       (sysclk_i),
    .rst_n     (sysrst_n_i),
    .push      (push),
    .push_data (fw_tdata),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      state        <= ST_RUN;
      ready_en     <= 1'b0;
      frame_o      <= '0;
      fw_marked_o  <= 1'b0;
      bytes_sent_o <= '0;
    end else begin
      state       <= next_state;
      ready_en    <= 1'b1;
      frame_o     <= frame_d;
      fw_marked_o <= marked_d;
      if (mark_issue) begin
        bytes_sent_o <= '0;
      end else if (data_issue) begin
        bytes_sent_o <= bytes_sent_o + 16'd1;
      end
    end
  end

  // The strobe sees the FIFO occupancy from before this cycle's push, so a
  // byte accepted on the strobe cycle waits for the next strobe.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    frame_d    = frame_o;
    marked_d   = 1'b0;
    data_issue = 1'b0;
    mark_issue = 1'b0;

    if (frame_stb_i) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        data_issue = 1'b1;
        frame_d    = build_frame(1'b1, 2'b00, fifo_head);
      end else if (state == ST_DRAIN) begin
        mark_issue = 1'b1;
        marked_d   = 1'b1;
        frame_d    = build_frame(1'b0, fw_mark_i, 8'h00);
      end else begin
        frame_d = '0;
      end
    end

    case (state)
      ST_RUN:    if (fw_mark_i != 2'b00) next_state = ST_DRAIN;
      ST_DRAIN:  if (mark_issue)         next_state = ST_MARKED;
      ST_MARKED: if (fw_mark_i == 2'b00) next_state = ST_RUN;
      default:   next_state = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_surfturf_fw_framer.sv
// tb/tb_surfturf_fw_framer.sv - self-checking bench for surfturf_fw_framer
module tb_surfturf_fw_framer;

  localparam int DEPTH = 2;
`ifdef FWFRAMER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [1:0]  mark = '0;
  logic        marked;
  logic        stb = 1'b0;
  logic [11:0] frame;
  logic [15:0] bytes;

  always #5 clk = ~clk;

  surfturf_fw_framer #(.SYS_CLK_TYPE("NONE"), .DEPTH(DEPTH)) dut (
    .sysclk_i     (clk),
    .sysrst_n_i   (rst_n),
    .fw_tdata     (tdata),
    .fw_tvalid    (tvalid),
    .fw_tready    (tready),
    .fw_mark_i    (mark),
    .fw_marked_o  (marked),
    .frame_stb_i  (stb),
    .frame_o      (frame),
    .bytes_sent_o (bytes)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered bytes plus flags for "mark pending"
  // and "mark issued, waiting for release".
  logic [7:0]  m_q[$];
  bit          m_armed, m_drain, m_wait, m_marked;
  logic [11:0] m_frame;
  logic [15:0] m_bytes;

  function automatic logic [11:0] mk(input bit v, input logic [1:0] m, input logic [7:0] d);
    logic [11:0] f;
    f = {1'b0, m, v, d};
    if (PAR_ON) f[11] = ^f[10:0];
    return f;
  endfunction

  function automatic bit m_tready();
    return m_armed && (m_q.size() < DEPTH) && !m_drain && !m_wait;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_armed = 0; m_drain = 0; m_wait = 0; m_marked = 0;
    m_frame = '0; m_bytes = '0;
  endtask

  task automatic model_step();
    bit acc, was_run, was_drain, was_wait;
    acc       = tvalid && m_tready();
    was_drain = m_drain;
    was_wait  = m_wait;
    was_run   = !m_drain && !m_wait;
    m_marked  = 0;
    if (stb) begin
      if (m_q.size() > 0) begin
        m_frame = mk(1'b1, 2'b00, m_q.pop_front());
        m_bytes = m_bytes + 16'd1;
      end else if (was_drain) begin
        m_frame  = mk(1'b0, mark, 8'h00);
        m_marked = 1;
        m_bytes  = '0;
        m_drain  = 0;
        m_wait   = 1;
      end else begin
        m_frame = '0;
      end
    end
    if (acc) m_q.push_back(tdata);
    if (was_run && mark != 2'b00) m_drain = 1;
    if (was_wait && mark == 2'b00) m_wait = 0;
    m_armed = 1;
  endtask

  bit          prev_stb = 0;
  int          n_marked = 0;
  int          n_acc = 0;
  logic [11:0] frames_log[$];

  task automatic cycle();
    chk("tready", 32'(tready), 32'(m_tready()));
    if (tvalid && tready) n_acc++;
    model_step();
    prev_stb = stb;
    @(posedge clk); #1;
    chk("frame", 32'(frame), 32'(m_frame));
    chk("marked", 32'(marked), 32'(m_marked));
    chk("bytes_sent", 32'(bytes), 32'(m_bytes));
    if (marked) n_marked++;
    if (prev_stb) frames_log.push_back(frame);
  endtask

  task automatic do_reset();
    tvalid = 0; stb = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_frame", 32'(frame), 32'h0);
    chk("rst_tready", 32'(tready), 32'h0);
    chk("rst_marked", 32'(marked), 32'h0);
    chk("rst_bytes", 32'(bytes), 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    prev_stb = 0;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [11:0] exp_frame;
    logic        exp_par;
  } vec_t;

  vec_t vt[6];

  initial begin
    int cnt, acc_after, seen, post, mk_frames, nxt;
    logic [7:0] got[$];

    vt[0] = '{8'h01, 12'h101, 1'b0};
    vt[1] = '{8'h03, 12'h103, 1'b1};
    vt[2] = '{8'h00, 12'h100, 1'b1};
    vt[3] = '{8'hFF, 12'h1FF, 1'b1};
    vt[4] = '{8'h07, 12'h107, 1'b0};
    vt[5] = '{8'hA5, 12'h1A5, 1'b1};

    model_reset();
    do_reset();

    // First cycle after release: tready held low (model checks it).
    cycle();

    // A byte pushed on a strobe cycle with an empty FIFO is not sent on that strobe.
    tvalid = 1; tdata = 8'h5A; stb = 1;
    cycle();
    chk("same_cycle_idle", 32'(frame), 32'h0);
    tvalid = 0; stb = 0;
    cycle();
    stb = 1; cycle(); stb = 0;
    chk("next_strobe_data", 32'(frame), 32'(mk(1'b1, 2'b00, 8'h5A)));
    cycle();

    // Table-driven frame encoding.
    for (int i = 0; i < 6; i++) begin
      tvalid = 1; tdata = vt[i].data;
      cycle();
      tvalid = 0; stb = 1;
      cycle();
      stb = 0;
      chk("table_frame", 32'(frame), 32'({PAR_ON & vt[i].exp_par, vt[i].exp_frame[10:0]}));
      cycle();
      chk("table_hold", 32'(frame), 32'({PAR_ON & vt[i].exp_par, vt[i].exp_frame[10:0]}));
    end

    // Stream 0x00..0x0F with a strobe every 8 cycles.
    do_reset();
    nxt = 0; got.delete();
    for (int c = 0; c < 400 && got.size() < 16; c++) begin
      stb = (c % 8 == 7);
      tvalid = (nxt < 16);
      tdata = 8'(nxt);
      if (tvalid && tready) nxt++;
      cycle();
      if (prev_stb && frame[8]) got.push_back(frame[7:0]);
    end
    tvalid = 0; stb = 0;
    chk("stream_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < got.size(); i++) chk("stream_order", 32'(got[i]), 32'(i));
    chk("stream_bytes_sent", 32'(bytes), 32'd16);

    // Fill with strobes held off, then resume.
    n_acc = 0; frames_log.delete();
    for (int c = 0; c < 8; c++) begin
      tvalid = 1; tdata = 8'(8'h80 + n_acc);
      cycle();
    end
    chk("fill_accepts", 32'(n_acc), 32'(DEPTH));
    chk("fill_tready_low", 32'(tready), 32'h0);
    for (int c = 0; c < 120; c++) begin
      tvalid = (n_acc < 12); tdata = 8'(8'h80 + n_acc);
      stb = (c % 4 == 3);
      cycle();
    end
    tvalid = 0; stb = 0;
    cnt = 0;
    foreach (frames_log[i]) if (frames_log[i][8]) cnt++;
    chk("resume_no_loss", 32'(cnt), 32'(n_acc));

    // Three bytes then mark 01.
    do_reset();
    n_acc = 0; frames_log.delete();
    for (int c = 0; c < 60 && n_acc < 3; c++) begin
      tvalid = 1; tdata = 8'(8'h40 + n_acc);
      stb = (c % 3 == 2);
      cycle();
    end
    tvalid = 0; stb = 0; mark = 2'b01;
    cnt = n_marked; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      stb = (c % 3 == 2);
      cycle();
      if (marked) seen = 1;
    end
    stb = 0;
    chk("mark01_seen", 32'(seen), 32'd1);
    mk_frames = 0;
    foreach (frames_log[i]) if (frames_log[i][8]) mk_frames++;
    chk("mark01_data_frames", 32'(mk_frames), 32'd3);
    chk("mark01_frame", 32'(frame), 32'(mk(1'b0, 2'b01, 8'h00)));
    chk("mark01_bytes", 32'(bytes), 32'h0);
    for (int c = 0; c < 3; c++) cycle();
    chk("mark01_one_pulse", 32'(n_marked - cnt), 32'd1);
    mark = 2'b00;
    for (int c = 0; c < 3; c++) cycle();

    // Mark 11 held 20 cycles after issue with bytes offered throughout.
    cnt = n_marked; seen = 0; post = 0; acc_after = 0; frames_log.delete();
    mark = 2'b11;
    for (int c = 0; c < 200 && post < 20; c++) begin
      stb = (c % 3 == 2);
      tvalid = 1; tdata = 8'($urandom);
      if (seen && tready) acc_after++;
      cycle();
      if (seen) post++;
      if (marked) seen = 1;
    end
    chk("mark11_seen", 32'(seen), 32'd1);
    chk("mark11_one_pulse", 32'(n_marked - cnt), 32'd1);
    chk("mark11_no_accepts", 32'(acc_after), 32'd0);
    mk_frames = 0;
    foreach (frames_log[i]) if (frames_log[i][10:9] != 2'b00) mk_frames++;
    chk("mark11_one_frame", 32'(mk_frames), 32'd1);
    mark = 2'b00; tvalid = 0; stb = 0;
    for (int c = 0; c < 4; c++) cycle();

    // Reset during DRAIN with two bytes buffered, mark still held afterwards.
    do_reset();
    cycle();
    tvalid = 1; tdata = 8'h11; cycle();
    tdata = 8'h22; cycle();
    tvalid = 0; stb = 1; cycle(); stb = 0;
    tvalid = 1; tdata = 8'h33; mark = 2'b01; cycle();
    tvalid = 0; cycle();
    chk("pre_reset_frame", 32'(frame), 32'(mk(1'b1, 2'b00, 8'h11)));
    do_reset();
    frames_log.delete();
    for (int c = 0; c < 30 && frames_log.size() == 0; c++) begin
      stb = (c % 3 == 2);
      cycle();
    end
    stb = 0;
    chk("post_reset_count", 32'(frames_log.size()), 32'd1);
    if (frames_log.size() > 0)
      chk("post_reset_mark_first", 32'(frames_log[0]), 32'(mk(1'b0, 2'b01, 8'h00)));
    mark = 2'b00;
    for (int c = 0; c < 3; c++) cycle();

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      stb = !prev_stb && ($urandom_range(0, 3) == 0);
      tvalid = $urandom_range(0, 1) == 1;
      tdata = 8'($urandom);
      if (mark == 2'b00 && !m_wait && $urandom_range(0, 39) == 0)
        mark = 2'($urandom_range(1, 3));
      else if (mark != 2'b00 && m_drain && $urandom_range(0, 9) == 0)
        mark = mark | 2'($urandom_range(1, 3));
      else if (mark != 2'b00 && m_wait && $urandom_range(0, 5) == 0)
        mark = 2'b00;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
